// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared types and helpers for the AXI4-Lite slave register bank.
//   resp_e      : AXI response codes (OKAY/EXOKAY/SLVERR/DECERR)
//   wr_state_e  : AW/W join states of the write path
//   rd_state_e  : read path states
//   apply_wstrb : byte-lane merge of write data into an existing word
// The merge helper works on the widest AXI4-Lite data bus (64 bits). Callers
// narrower than that cast in and out.
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

  localparam int unsigned AXIL_MAX_DLEN = 64;
  localparam int unsigned AXIL_MAX_SLEN = AXIL_MAX_DLEN / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  function automatic logic [AXIL_MAX_DLEN-1:0] apply_wstrb(
    input logic [AXIL_MAX_DLEN-1:0] old,
    input logic [AXIL_MAX_DLEN-1:0] wdata,
    input logic [AXIL_MAX_SLEN-1:0] wstrb
  );
    logic [AXIL_MAX_DLEN-1:0] merged;
    merged = old;
    for (int b = 0; b < int'(AXIL_MAX_SLEN); b++) begin
      if (wstrb[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_wr_join.sv
// -----------------------------------------------------------------------------
// axi4_lite_wr_join
// Joins the independent AW and W channels of an AXI4-Lite write into a single
// commit, then holds the B channel until the master accepts it.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// W_IDLE    | both AW and W accepted; nothing pending
// W_HAVE_AW | address latched, waiting for write data
// W_HAVE_W  | data/strobes latched, waiting for write address
// W_RESP    | write committed, bvalid held until bready
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   aw*_i / awready_o    write address channel
//   w*_i  / wready_o     write data channel
//   bvalid_o / bready_i  write response handshake (bresp owned by parent)
//   commit_o             one-cycle pulse in the cycle whose edge completes
//                        the AW/W pair; commit_*_o carry the joined beat
// -----------------------------------------------------------------------------
module axi4_lite_wr_join
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ALEN = 32,
  parameter int unsigned DLEN = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [ALEN-1:0]   awaddr_i,
  input  logic [2:0]        awprot_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [DLEN-1:0]   wdata_i,
  input  logic [DLEN/8-1:0] wstrb_i,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic              commit_o,
  output logic [ALEN-1:0]   commit_addr_o,
  output logic [2:0]        commit_prot_o,
  output logic [DLEN-1:0]   commit_data_o,
  output logic [DLEN/8-1:0] commit_strb_o
);

  wr_state_e         state_q, state_d;
  logic              en_q;
  logic [ALEN-1:0]   addr_q, addr_d;
  logic [2:0]        prot_q, prot_d;
  logic [DLEN-1:0]   data_q, data_d;
  logic [DLEN/8-1:0] strb_q, strb_d;

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= W_IDLE;
      en_q    <= 1'b0;
      addr_q  <= '0;
      prot_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b1;
      addr_q  <= addr_d;
      prot_q  <= prot_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    prot_d        = prot_q;
    data_d        = data_q;
    strb_d        = strb_q;
    awready_o     = 1'b0;
    wready_o      = 1'b0;
    bvalid_o      = 1'b0;
    commit_o      = 1'b0;
    commit_addr_o = addr_q;
    commit_prot_o = prot_q;
    commit_data_o = data_q;
    commit_strb_o = strb_q;

    case (state_q)
      W_IDLE: begin
        awready_o = en_q;
        wready_o  = en_q;
        if (en_q && awvalid_i && wvalid_i) begin
          commit_o      = 1'b1;
          commit_addr_o = awaddr_i;
          commit_prot_o = awprot_i;
          commit_data_o = wdata_i;
          commit_strb_o = wstrb_i;
          state_d       = W_RESP;
        end else if (en_q && awvalid_i) begin
          addr_d  = awaddr_i;
          prot_d  = awprot_i;
          state_d = W_HAVE_AW;
        end else if (en_q && wvalid_i) begin
          data_d  = wdata_i;
          strb_d  = wstrb_i;
          state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          commit_o      = 1'b1;
          commit_data_o = wdata_i;
          commit_strb_o = wstrb_i;
          state_d       = W_RESP;
        end
      end
      W_HAVE_W: begin
        awready_o = 1'b1;
        if (awvalid_i) begin
          commit_o      = 1'b1;
          commit_addr_o = awaddr_i;
          commit_prot_o = awprot_i;
          state_d       = W_RESP;
        end
      end
      W_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// -----------------------------------------------------------------------------
// axi4_lite_slave_regs
// AXI4-Lite slave terminating AW/W/B/AR/R into NREGS 32-bit registers that are
// exposed flat to fabric logic, with a one-cycle write pulse per register.
//
// state  | meaning (read path)
// -------+-------------------------------------------------------------
// R_IDLE | arready high, waiting for a read address
// R_RESP | rdata/rresp held with rvalid until rready
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   aw*, w*, b*              AXI4-Lite write channels
//   ar*, r*                  AXI4-Lite read channels
//   reg_q                    register i at [i*DLEN +: DLEN]
//   wr_pulse                 one-cycle strobe after a successful write
//
// Optional build macro AXIL_REGS_PROT_CHECK_EN: when defined, unprivileged
// accesses (awprot[0]/arprot[0] = 0) get SLVERR and never touch a register.
// When undefined the prot fields are accepted and ignored.
// -----------------------------------------------------------------------------
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int unsigned      ALEN       = 32,
  parameter int unsigned      DLEN       = 32,
  parameter int unsigned      NREGS      = 16,
  parameter logic [DLEN-1:0]  BASE_RESET = '0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ALEN-1:0]       awaddr,
  input  logic [2:0]            awprot,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DLEN-1:0]       wdata,
  input  logic [DLEN/8-1:0]     wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ALEN-1:0]       araddr,
  input  logic [2:0]            arprot,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DLEN-1:0]       rdata,
  output logic [1:0]            rresp,
  output logic [NREGS*DLEN-1:0] reg_q,
  output logic [NREGS-1:0]      wr_pulse
);

  localparam int unsigned    SLEN    = DLEN / 8;
  localparam int unsigned    IDX_LSB = $clog2(SLEN);
  localparam int unsigned    IDX_W   = $clog2(NREGS);
  localparam logic [ALEN-1:0] SPAN   = ALEN'(NREGS * SLEN);

  // ---------------------------------------------------------------- write path
  logic              commit;
  logic [ALEN-1:0]   commit_addr;
  logic [2:0]        commit_prot;
  logic [DLEN-1:0]   commit_data;
  logic [SLEN-1:0]   commit_strb;

  axi4_lite_wr_join #(
    .ALEN (ALEN),
    .DLEN (DLEN)
  ) u_wr_join (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .awvalid_i     (awvalid),
    .awready_o     (awready),
    .awaddr_i      (awaddr),
    .awprot_i      (awprot),
    .wvalid_i      (wvalid),
    .wready_o      (wready),
    .wdata_i       (wdata),
    .wstrb_i       (wstrb),
    .bvalid_o      (bvalid),
    .bready_i      (bready),
    .commit_o      (commit),
    .commit_addr_o (commit_addr),
    .commit_prot_o (commit_prot),
    .commit_data_o (commit_data),
    .commit_strb_o (commit_strb)
  );

  logic [DLEN-1:0]  regs_q [NREGS];
  logic             wr_in_range, wr_allowed, wr_ok;
  logic             rd_in_range, rd_allowed;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [DLEN-1:0]  wr_merged;
  logic [NREGS-1:0] wr_pulse_q, wr_pulse_d;
  resp_e            bresp_q;
  logic             unused_prot;

  assign wr_in_range = (commit_addr < SPAN);
  assign rd_in_range = (araddr < SPAN);
  assign wr_idx      = commit_addr[IDX_LSB +: IDX_W];
  assign rd_idx      = araddr[IDX_LSB +: IDX_W];

`ifdef AXIL_REGS_PROT_CHECK_EN
  assign wr_allowed  = wr_in_range && commit_prot[0];
  assign rd_allowed  = rd_in_range && arprot[0];
  assign unused_prot = ^{commit_prot[2:1], arprot[2:1]};
`else
  assign wr_allowed  = wr_in_range;
  assign rd_allowed  = rd_in_range;
  assign unused_prot = ^{commit_prot, arprot};
`endif

  assign wr_ok      = commit && wr_allowed;
  assign wr_merged  = DLEN'(apply_wstrb(AXIL_MAX_DLEN'(regs_q[wr_idx]),
                                        AXIL_MAX_DLEN'(commit_data),
                                        AXIL_MAX_SLEN'(commit_strb)));
  // A zero-strobe write still counts as a successful write and pulses.
  assign wr_pulse_d = wr_ok ? (NREGS'(1) << wr_idx) : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= BASE_RESET;
    end else if (wr_ok) begin
      regs_q[wr_idx] <= wr_merged;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_pulse_q <= '0;
      bresp_q    <= OKAY;
    end else begin
      wr_pulse_q <= wr_pulse_d;
      if (commit) bresp_q <= wr_allowed ? OKAY : SLVERR;
    end
  end

  assign bresp    = bresp_q;
  assign wr_pulse = wr_pulse_q;

  for (genvar g = 0; g < int'(NREGS); g++) begin : g_flat
    assign reg_q[g*DLEN +: DLEN] = regs_q[g];
  end

  // ----------------------------------------------------------------- read path
  rd_state_e       rd_state_q, rd_state_d;
  logic            ar_en_q;
  logic [DLEN-1:0] rdata_q, rdata_d;
  resp_e           rresp_q, rresp_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      ar_en_q    <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      ar_en_q    <= 1'b1;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // rdata is captured from regs_q before any write landing on the same edge.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        arready = ar_en_q;
        if (ar_en_q && arvalid) begin
          rd_state_d = R_RESP;
          if (rd_allowed) begin
            rdata_d = regs_q[rd_idx];
            rresp_d = OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = SLVERR;
          end
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
module tb_axi4_lite_slave_regs;

  localparam int ALEN  = 32;
  localparam int DLEN  = 32;
  localparam int NREGS = 16;
  localparam int SLEN  = DLEN / 8;
`ifdef AXIL_REGS_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b0;
  logic                  awvalid = 1'b0, awready;
  logic [ALEN-1:0]       awaddr = '0;
  logic [2:0]            awprot = '0;
  logic                  wvalid = 1'b0, wready;
  logic [DLEN-1:0]       wdata = '0;
  logic [SLEN-1:0]       wstrb = '0;
  logic                  bvalid, bready = 1'b1;
  logic [1:0]            bresp;
  logic                  arvalid = 1'b0, arready;
  logic [ALEN-1:0]       araddr = '0;
  logic [2:0]            arprot = '0;
  logic                  rvalid, rready = 1'b1;
  logic [DLEN-1:0]       rdata;
  logic [1:0]            rresp;
  logic [NREGS*DLEN-1:0] reg_q;
  logic [NREGS-1:0]      wr_pulse;

  axi4_lite_slave_regs #(.ALEN(ALEN), .DLEN(DLEN), .NREGS(NREGS), .BASE_RESET('0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake (cycle %0d)", name, cyc);
  endtask

  // ---------------------------------------------------------- reference model
  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  typedef struct { int due; logic [NREGS-1:0] mask; } pulse_t;

  logic [31:0] model [NREGS];
  logic [31:0] aw_a_q[$];
  logic [2:0]  aw_p_q[$];
  logic [31:0] w_d_q[$];
  logic [3:0]  w_s_q[$];
  logic [1:0]  b_q[$];
  rexp_t       r_q[$];
  pulse_t      p_q[$];

  initial for (int i = 0; i < NREGS; i++) model[i] = '0;

  function automatic bit allowed(input logic [31:0] a, input logic [2:0] p);
    if (a >= 32'(NREGS * SLEN)) return 1'b0;
    return p[0] || !PROT_EN;
  endfunction

  // Observes bus handshakes just before the edge that completes them and
  // predicts responses: nth AW pairs with nth W; reads see pre-write contents.
  always @(negedge aclk) begin
    if (!aresetn) begin
      aw_a_q.delete(); aw_p_q.delete(); w_d_q.delete(); w_s_q.delete();
      b_q.delete(); r_q.delete(); p_q.delete();
      for (int i = 0; i < NREGS; i++) model[i] = '0;
    end else begin
      if (arvalid && arready) begin
        rexp_t e;
        if (allowed(araddr, arprot)) begin
          e.data = model[araddr / SLEN];
          e.resp = 2'b00;
        end else begin
          e.data = '0;
          e.resp = 2'b10;
        end
        r_q.push_back(e);
      end
      if (awvalid && awready) begin
        aw_a_q.push_back(awaddr);
        aw_p_q.push_back(awprot);
      end
      if (wvalid && wready) begin
        w_d_q.push_back(wdata);
        w_s_q.push_back(wstrb);
      end
      if (aw_a_q.size() > 0 && w_d_q.size() > 0) begin
        logic [31:0] a, d;
        logic [2:0]  p;
        logic [3:0]  s;
        pulse_t      pe;
        a = aw_a_q.pop_front(); p = aw_p_q.pop_front();
        d = w_d_q.pop_front();  s = w_s_q.pop_front();
        if (allowed(a, p)) begin
          for (int b = 0; b < SLEN; b++)
            if (s[b]) model[a / SLEN][b*8 +: 8] = d[b*8 +: 8];
          b_q.push_back(2'b00);
          pe.due  = cyc + 1;
          pe.mask = '0;
          pe.mask[a / SLEN] = 1'b1;
          p_q.push_back(pe);
        end else begin
          b_q.push_back(2'b10);
        end
      end
    end
  end

  // ------------------------------------------------------------------ monitor
  always @(negedge aclk) begin
    if (aresetn) begin
      logic [NREGS-1:0] exp_m;
      if (bvalid && bready) begin
        if (b_q.size() == 0) timeout("b_unexpected");
        else chk("bresp", bresp, b_q.pop_front());
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) timeout("r_unexpected");
        else begin
          rexp_t e;
          e = r_q.pop_front();
          chk("rdata", rdata, e.data);
          chk("rresp", rresp, e.resp);
        end
      end
      exp_m = '0;
      if (p_q.size() > 0 && p_q[0].due == cyc) exp_m = p_q.pop_front().mask;
      if (wr_pulse != '0 || exp_m != '0) chk("wr_pulse", wr_pulse, exp_m);
    end
  end

  // ------------------------------------------------------------------ drivers
  // All drive tasks start and end at 1 time unit after a rising edge.
  task automatic send_aw(input logic [31:0] a, input logic [2:0] p, input int dly);
    bit done = 1'b0;
    if (dly > 0) begin repeat (dly) @(posedge aclk); #1; end
    awvalid = 1'b1; awaddr = a; awprot = p;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge aclk);
      if (awready) begin @(posedge aclk); #1; done = 1'b1; end
    end
    awvalid = 1'b0;
    if (!done) timeout("aw_hs");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit done = 1'b0;
    if (dly > 0) begin repeat (dly) @(posedge aclk); #1; end
    wvalid = 1'b1; wdata = d; wstrb = s;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge aclk);
      if (wready) begin @(posedge aclk); #1; done = 1'b1; end
    end
    wvalid = 1'b0;
    if (!done) timeout("w_hs");
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [2:0] p, input int dly);
    bit done = 1'b0;
    if (dly > 0) begin repeat (dly) @(posedge aclk); #1; end
    arvalid = 1'b1; araddr = a; arprot = p;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge aclk);
      if (arready) begin @(posedge aclk); #1; done = 1'b1; end
    end
    arvalid = 1'b0;
    if (!done) timeout("ar_hs");
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [2:0] p, input int da, input int dw);
    fork
      send_aw(a, p, da);
      send_w(d, s, dw);
    join
  endtask

  task automatic wait_b();
    bit done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(posedge aclk); #1;
      if (!bvalid) done = 1'b1;
    end
    if (!done) timeout("b_drain");
  endtask

  task automatic wait_r();
    bit done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(posedge aclk); #1;
      if (!rvalid) done = 1'b1;
    end
    if (!done) timeout("r_drain");
  endtask

  task automatic compare_all(input string name);
    for (int i = 0; i < NREGS; i++) chk(name, reg_q[i*DLEN +: DLEN], model[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // ------------------------------------------------------------------ stimulus
  bit wdone = 1'b0, rdone = 1'b0;

  initial begin
    #2;
    chk("rst_ready", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_pulse", wr_pulse, '0);
    chk("rst_resp", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, '0);
    for (int i = 0; i < NREGS; i++) chk("rst_reg", reg_q[i*DLEN +: DLEN], '0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1 chk("ready_before_edge", {awready, wready, arready}, 3'b000);
    @(posedge aclk); #1;
    chk("ready_after_edge", {awready, wready, arready}, 3'b111);

    // AW and W in the same cycle
    wr(32'h04, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0);
    chk("t1_bvalid", bvalid, 1'b1);
    chk("t1_bresp", bresp, 2'b00);
    chk("t1_pulse", wr_pulse, 16'h0002);
    wait_b();
    send_ar(32'h04, 3'b001, 0);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    chk("t1_rresp", rresp, 2'b00);
    wait_r();

    // W leads AW by three cycles
    send_w(32'h11223344, 4'h3, 0);
    repeat (3) begin
      @(negedge aclk);
      chk("t2_ready", {awready, wready}, 2'b10);
    end
    @(posedge aclk); #1;
    send_aw(32'h08, 3'b001, 0);
    wait_b();
    chk("t2_reg2", reg_q[2*DLEN +: DLEN], 32'h00003344);

    // B back-pressure blocks the next write
    bready = 1'b0;
    wr(32'h0C, 32'h12345678, 4'hF, 3'b001, 0, 0);
    fork
      wr(32'h10, 32'hCAFEF00D, 4'hF, 3'b001, 0, 0);
      begin
        repeat (5) begin
          @(negedge aclk);
          chk("t3_hold", {bvalid, bresp, awready, wready}, 5'b10000);
        end
        @(posedge aclk); #1;
        bready = 1'b1;
      end
    join
    wait_b();
    chk("t3_reg3", reg_q[3*DLEN +: DLEN], 32'h12345678);
    chk("t3_reg4", reg_q[4*DLEN +: DLEN], 32'hCAFEF00D);

    // Out of range write and read
    wr(32'h40, 32'hFFFFFFFF, 4'hF, 3'b001, 0, 0);
    chk("t4_bresp", bresp, 2'b10);
    chk("t4_pulse", wr_pulse, '0);
    wait_b();
    send_ar(32'h44, 3'b001, 0);
    chk("t4_rresp", rresp, 2'b10);
    chk("t4_rdata", rdata, '0);
    wait_r();
    compare_all("t4_regs");

    // Read and write of reg3 on the same edge
    fork
      wr(32'h0C, 32'hA5A5A5A5, 4'hF, 3'b001, 0, 0);
      send_ar(32'h0C, 3'b001, 0);
    join
    chk("t5_old", rdata, 32'h12345678);
    wait_b();
    wait_r();
    send_ar(32'h0C, 3'b001, 0);
    chk("t5_new", rdata, 32'hA5A5A5A5);
    wait_r();

    // Zero strobe and protection attribute
    wr(32'h08, 32'hFFFFFFFF, 4'h0, 3'b001, 0, 0);
    chk("t6_zero_strb_pulse", wr_pulse, 16'h0004);
    wait_b();
    chk("t6_zero_strb_reg", reg_q[2*DLEN +: DLEN], 32'h00003344);
    wr(32'h00, 32'h00000055, 4'hF, 3'b000, 0, 0);
    chk("t6_unpriv_bresp", bresp, PROT_EN ? 2'b10 : 2'b00);
    wait_b();
    chk("t6_unpriv_reg0", reg_q[0 +: DLEN], PROT_EN ? 32'h0 : 32'h55);
    wr(32'h00, 32'h00000066, 4'hF, 3'b001, 0, 0);
    chk("t6_priv_bresp", bresp, 2'b00);
    wait_b();
    send_ar(32'h00, 3'b000, 0);
    chk("t6_unpriv_rresp", rresp, PROT_EN ? 2'b10 : 2'b00);
    wait_r();

    // Reset while a write response is pending
    bready = 1'b0;
    wr(32'h14, 32'h77777777, 4'hF, 3'b001, 0, 0);
    chk("t7_pending", bvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("t7_bvalid_drop", bvalid, 1'b0);
    for (int i = 0; i < NREGS; i++) chk("t7_reg_reset", reg_q[i*DLEN +: DLEN], '0);
    bready = 1'b1;
    @(negedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    compare_all("t7_regs");

    // Randomized concurrent traffic with random back-pressure
    fork
      begin
        repeat (80) begin
          logic [31:0] a;
          a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(64, 255)) : 32'($urandom_range(0, 63));
          wr(a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
             $urandom_range(0, 3), $urandom_range(0, 3));
        end
        wdone = 1'b1;
      end
      begin
        repeat (80) begin
          logic [31:0] a;
          a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(64, 255)) : 32'($urandom_range(0, 63));
          send_ar(a, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
        end
        rdone = 1'b1;
      end
      begin
        while (!(wdone && rdone)) begin
          @(posedge aclk); #1;
          bready = ($urandom_range(0, 3) != 0);
          rready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bready = 1'b1;
    rready = 1'b1;
    repeat (20) @(posedge aclk);
    #1;
    chk("drain_b", 32'(b_q.size()), 0);
    chk("drain_r", 32'(r_q.size()), 0);
    compare_all("final_regs");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
